// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : usr_pkg
// Description : Shared definitions for the universal shift register:
//               operation mode encodings and the frame-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  // Operation encodings presented on the 'mode' input
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Width of a counter able to hold 0..width inclusive
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usr_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : usr_frame_counter
// Description : Counts shift events within a frame of WIDTH shifts. The count
//               wraps to zero on the WIDTH-th shift and frame_done pulses high
//               for exactly one cycle afterwards. 'clear' aborts the frame
//               without a pulse.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               shift_ev   - one shift taken this cycle
//               clear      - abort current frame (parallel load)
//               cnt        - shifts completed in the current frame
//               frame_done - registered single-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module usr_frame_counter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_ev,
  input  logic                     clear,
  output logic [cnt_w(WIDTH)-1:0]  cnt,
  output logic                     frame_done
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;        // pulse only on the cycle after the last shift
    if (clear) begin
      cnt_d = '0;
    end else if (shift_ev) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_universal
// Description : Parametrised universal shift register (hold / shift left /
//               shift right / parallel load) with a per-frame shift counter
//               that pulses frame_done after WIDTH shifts.
// Config      : USR_ROTATE_EN - when defined, adds input 'rot'; with rot=1
//               shifts recirculate the outgoing bit instead of taking si_l/si_r.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               en              - operation enable (0 = hold)
//               mode            - 00 hold, 01 shl, 10 shr, 11 load
//               si_l / si_r     - serial inputs for left / right shifts
//               pin             - parallel load data
//               pout            - register contents
//               so_l / so_r     - MSB / LSB of pout (combinational)
//               cnt, frame_done - frame progress and end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_universal
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
`ifdef USR_ROTATE_EN
  input  logic                     rot,
`endif
  input  logic                     si_l,
  input  logic                     si_r,
  input  logic [WIDTH-1:0]         pin,
  output logic [WIDTH-1:0]         pout,
  output logic                     so_l,
  output logic                     so_r,
  output logic [cnt_w(WIDTH)-1:0]  cnt,
  output logic                     frame_done
);

  logic [WIDTH-1:0] pout_q, pout_d;
  logic             fill_l, fill_r;
  logic             shift_ev, clear;

  // Bit entering the register on each shift direction
`ifdef USR_ROTATE_EN
  assign fill_l = rot ? pout_q[WIDTH-1] : si_l;
  assign fill_r = rot ? pout_q[0]       : si_r;
`else
  assign fill_l = si_l;
  assign fill_r = si_r;
`endif

  always_comb begin
    pout_d   = pout_q;
    shift_ev = 1'b0;
    clear    = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHL: begin
          pout_d   = {pout_q[WIDTH-2:0], fill_l};
          shift_ev = 1'b1;
        end
        MODE_SHR: begin
          pout_d   = {fill_r, pout_q[WIDTH-1:1]};
          shift_ev = 1'b1;
        end
        MODE_LOAD: begin
          pout_d = pin;
          clear  = 1'b1;
        end
        default: ;              // MODE_HOLD
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pout_q <= RESET_VAL;
    end else begin
      pout_q <= pout_d;
    end
  end

  usr_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .shift_ev   (shift_ev),
    .clear      (clear),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  assign pout = pout_q;
  assign so_l = pout_q[WIDTH-1];
  assign so_r = pout_q[0];

endmodule
`default_nettype wire
